// File: rtl/icache_mshr_arbiter.sv
// icache_mshr_arbiter
//   Tracks instruction-cache MSHR entries. It allocates free entries,
//   round-robin arbitrates entry requests onto a single downstream txreq
//   channel, and matches linefill completions back to their owning entries.
//
// Ports
//   clk, rst_n          : clock (rising edge) and asynchronous active-low reset
//   alloc_vld/rdy/id    : miss allocation handshake; id = lowest free entry
//   ent_release         : per-entry free pulse (also aborts an issued request)
//   ent_busy            : per-entry allocated flag
//   ent_req_vld/addr    : per-entry downstream request and packed addresses
//   ent_req_gnt         : per-entry pulse, same cycle as the txreq handshake
//   txreq_*             : downstream request channel, txnid = entry index
//   rxdat_*             : linefill beats; the last beat completes the owner
//   ent_fill_done       : per-entry pulse, cycle after the last fill beat
//   mshr_full, outstanding_cnt, rsp_err : status (rsp_err is sticky)
module icache_mshr_arbiter #(
  parameter int ENTRY_NUM   = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int TXNID_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_vld,
  output logic                            alloc_rdy,
  output logic [$clog2(ENTRY_NUM)-1:0]    alloc_id,
  input  logic [ENTRY_NUM-1:0]            ent_release,
  output logic [ENTRY_NUM-1:0]            ent_busy,
  input  logic [ENTRY_NUM-1:0]            ent_req_vld,
  input  logic [ENTRY_NUM*ADDR_WIDTH-1:0] ent_req_addr,
  output logic [ENTRY_NUM-1:0]            ent_req_gnt,
  output logic                            txreq_vld,
  input  logic                            txreq_rdy,
  output logic [ADDR_WIDTH-1:0]           txreq_addr,
  output logic [TXNID_WIDTH-1:0]          txreq_txnid,
  input  logic                            rxdat_vld,
  input  logic                            rxdat_last,
  input  logic [TXNID_WIDTH-1:0]          rxdat_txnid,
  output logic [ENTRY_NUM-1:0]            ent_fill_done,
  output logic                            mshr_full,
  output logic [$clog2(ENTRY_NUM):0]      outstanding_cnt,
  output logic                            rsp_err
);

  localparam int IDW = $clog2(ENTRY_NUM);
  localparam logic [TXNID_WIDTH:0] ENTRY_LIMIT = (TXNID_WIDTH+1)'(ENTRY_NUM);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_reg;
  logic [ENTRY_NUM-1:0]    busy_reg, busy_next;
  logic [ENTRY_NUM-1:0]    issued_reg, issued_next;
  logic [ENTRY_NUM-1:0]    fill_done_reg, fill_done_next;
  logic                    rsp_err_reg;
  logic [IDW-1:0]          rr_ptr_reg;
  logic [IDW-1:0]          win_reg;
  logic                    txreq_vld_reg;
  logic [ADDR_WIDTH-1:0]   txreq_addr_reg;
  logic [TXNID_WIDTH-1:0]  txreq_txnid_reg;

  logic [ADDR_WIDTH-1:0]   addr_arr [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]    eligible;
  logic [ENTRY_NUM-1:0]    arb_mask;
  logic [IDW-1:0]          arb_start, arb_idx, cand;
  logic                    arb_found;
  logic [IDW-1:0]          alloc_idx;
  logic                    alloc_fire, hs;
  logic                    fill_last, fill_ok;
  logic [IDW-1:0]          fill_idx;
  logic [IDW:0]            cnt;

  for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
    assign addr_arr[gi] = ent_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign eligible[gi] = busy_reg[gi] & ent_req_vld[gi] & ~issued_reg[gi];
  end

  // Lowest-index free entry, taken from the registered (pre-release) vector.
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!busy_reg[i]) alloc_idx = IDW'(i);
    end
  end

  assign alloc_rdy  = ~&busy_reg;
  assign mshr_full  = &busy_reg;
  assign alloc_id   = alloc_idx;
  assign alloc_fire = alloc_vld & alloc_rdy;
  assign hs         = (state_reg == SEND) & txreq_rdy;

  // One shared round-robin search. From IDLE it starts at rr_ptr; on a SEND
  // handshake it starts just past the current winner (the new rr_ptr) and
  // excludes the winner, whose issued bit only lands next cycle.
  always_comb begin
    arb_mask  = eligible;
    arb_start = rr_ptr_reg;
    if (state_reg == SEND) begin
      arb_mask[win_reg] = 1'b0;
      arb_start         = win_reg + IDW'(1);
    end
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      cand = arb_start + IDW'(k);
      if (!arb_found && arb_mask[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A completing fill must name an in-range entry that is actually issued.
  assign fill_last = rxdat_vld & rxdat_last;
  assign fill_idx  = rxdat_txnid[IDW-1:0];
  assign fill_ok   = fill_last && ({1'b0, rxdat_txnid} < ENTRY_LIMIT) && issued_reg[fill_idx];

  always_comb begin
    busy_next = busy_reg & ~ent_release;
    if (alloc_fire) busy_next[alloc_idx] = 1'b1;

    issued_next = issued_reg;
    if (hs) issued_next[win_reg] = 1'b1;
    if (fill_ok) issued_next[fill_idx] = 1'b0;
    issued_next = issued_next & ~ent_release;

    fill_done_next = '0;
    if (fill_ok) fill_done_next[fill_idx] = 1'b1;

    ent_req_gnt = '0;
    if (hs) ent_req_gnt[win_reg] = 1'b1;

    cnt = '0;
    for (int i = 0; i < ENTRY_NUM; i++) cnt = cnt + (IDW+1)'(issued_reg[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg      <= '0;
      issued_reg    <= '0;
      fill_done_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      busy_reg      <= busy_next;
      issued_reg    <= issued_next;
      fill_done_reg <= fill_done_next;
      if (fill_last && !fill_ok) rsp_err_reg <= 1'b1;
    end
  end

  // Txreq FSM: output registers are loaded only when a new winner is chosen,
  // so address and txnid stay frozen while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      win_reg         <= '0;
      txreq_vld_reg   <= 1'b0;
      txreq_addr_reg  <= '0;
      txreq_txnid_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_found) begin
            state_reg       <= SEND;
            txreq_vld_reg   <= 1'b1;
            win_reg         <= arb_idx;
            txreq_addr_reg  <= addr_arr[arb_idx];
            txreq_txnid_reg <= TXNID_WIDTH'(arb_idx);
          end
        end
        SEND: begin
          if (txreq_rdy) begin
            rr_ptr_reg <= win_reg + IDW'(1);
            if (arb_found) begin
              win_reg         <= arb_idx;
              txreq_addr_reg  <= addr_arr[arb_idx];
              txreq_txnid_reg <= TXNID_WIDTH'(arb_idx);
            end else begin
              state_reg     <= IDLE;
              txreq_vld_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          txreq_vld_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ent_busy        = busy_reg;
  assign ent_fill_done   = fill_done_reg;
  assign rsp_err         = rsp_err_reg;
  assign outstanding_cnt = cnt;
  assign txreq_vld       = txreq_vld_reg;
  assign txreq_addr      = txreq_addr_reg;
  assign txreq_txnid     = txreq_txnid_reg;

endmodule
